// File: rtl/lane_gate_pkg.sv
// Shared definitions for the lane gate FIFO: gate op encoding and the
// 12-bit result view used by the lanes.
package lane_gate_pkg;

  typedef enum logic [1:0] {
    GATE_XOR = 2'd0,
    GATE_AND = 2'd1,
    GATE_OR  = 2'd2,
    GATE_NOT = 2'd3
  } gate_op_e;

  typedef logic [0:3][2:4] gate_res_t;

  localparam int unsigned RES_W = $bits(gate_res_t);

endpackage

// File: rtl/lane_gate_fifo_mem.sv
// Circular FIFO storage with wrapping pointers and occupancy count.
// Storage is not reset; only pointers and count are.
module lane_gate_fifo_mem #(
  parameter int unsigned DW    = 14,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DW-1:0]                wdata,
  output logic [DW-1:0]                rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pops on empty are dropped; pushes on full cannot be granted upstream
  assign do_push = push && !rst && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/lane_gate_fifo.sv
// Round-robin arbiter over CH request lanes, applies each lane's bitwise
// gate op and queues the result with its source channel in a FIFO.
module lane_gate_fifo
  import lane_gate_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CH-1:0]                         in_valid,
  output logic [CH-1:0]                         in_ready,
  input  logic [CH-1:0][1:0]                    in_op,
  input  logic [CH-1:0][W-1:0]                  in_a,
  input  logic [CH-1:0][W-1:0]                  in_b,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [W-1:0]                          out_data,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0] out_ch,
  output logic [$clog2(DEPTH+1)-1:0]            count
);

  localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH+1);
  localparam int unsigned DW  = W + CHW;

  logic [CHW-1:0] rr_ptr;
  logic [CHW-1:0] idx;
  logic [CHW-1:0] gnt_idx;
  logic           gnt_any;
  logic           full;
  logic           push;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   res;
  logic [DW-1:0]  rdata;

  assign full = (count == CW'(DEPTH));

  // First valid lane at or after rr_ptr wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      idx = CHW'((32'(rr_ptr) + i) % CH);
      if (!gnt_any && in_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign in_ready = (gnt_any && !full && !rst) ? (CH'(1) << gnt_idx) : '0;
  assign push     = gnt_any && !full && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= (gnt_idx == CHW'(CH-1)) ? '0 : gnt_idx + CHW'(1);
    end
  end

  // 4-state operators already follow the gate tables (Z behaves as X)
  always_comb begin
    op_a = in_a[gnt_idx];
    op_b = in_b[gnt_idx];
    res  = '0;
    case (gate_op_e'(in_op[gnt_idx]))
      GATE_XOR: res = op_a ^ op_b;
      GATE_AND: res = op_a & op_b;
      GATE_OR:  res = op_a | op_b;
      GATE_NOT: res = ~op_a;
      default:  res = ~op_a;
    endcase
  end

  lane_gate_fifo_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_ready),
    .wdata ({res, gnt_idx}),
    .rdata (rdata),
    .count (count)
  );

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? rdata[DW-1:CHW] : '0;
  assign out_ch    = out_valid ? rdata[CHW-1:0]  : '0;

endmodule

// File: doc/lane_gate_fifo.md
LANE_GATE_FIFO -- requirements
Module: lane_gate_fifo

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of input channels (>=1).
REQ-002 SHALL have parameter W, default 12, meaning operand/result width in bits, viewed as packed [0:3][2:4].
REQ-003 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  CH  per-channel request.
REQ-007 SHALL have port in_ready  output  CH  per-channel accept (one-hot or zero).
REQ-008 SHALL have port in_op  input  CH x 2  per-channel gate op: 0 XOR, 1 AND, 2 OR, 3 NOT(a).
REQ-009 SHALL have port in_a  input  CH x W  operand a, 4-state logic.
REQ-010 SHALL have port in_b  input  CH x W  operand b, 4-state logic, ignored for op 3.
REQ-011 SHALL have port out_valid  output  1  FIFO head valid.
REQ-012 SHALL have port out_ready  input  1  consumer accept.
REQ-013 SHALL have port out_data  output  W  head result.
REQ-014 SHALL have port out_ch  output  $clog2(CH) (min 1)  source channel of head.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 Transfer on input i SHALL occur when in_valid[i] && in_ready[i]; on output when out_valid && out_ready.
REQ-017 in_ready SHALL depend only on registered state and in_valid: at most one bit set, none when count==DEPTH; no combinational path from out_ready.
REQ-018 Arbitration SHALL be round-robin: search starts at rr_ptr, first valid channel wins; after grant rr_ptr = granted+1 mod CH; with no grant rr_ptr holds.
REQ-019 Result SHALL be bitwise gate op, per IEEE 1800 4-state gate tables (0 dominates AND, 1 dominates OR, otherwise X/Z in -> X out; Z inputs treated as X).
REQ-020 Accepted result and channel index SHALL be written at the tail on the accepting edge; first visibility on out_* one cycle after acceptance when FIFO was empty.
REQ-021 out_data/out_ch SHALL hold stable while out_valid && !out_ready.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; push on full is impossible by REQ-017; pop on empty SHALL be ignored.
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; count SHALL equal writes minus reads at all times.
REQ-024 out_valid SHALL equal (count != 0).

Reset
REQ-025 On rst high at a clk edge: count=0, pointers=0, rr_ptr=0, out_valid=0, in_ready=0 during the reset cycle; out_data/out_ch=0.
REQ-026 Reset mid-operation SHALL discard all stored entries; no transfer SHALL be reported in the reset cycle.
REQ-027 Storage array SHALL NOT require reset.

Structure
REQ-028 Op encoding enum (GATE_XOR, GATE_AND, GATE_OR, GATE_NOT) and the packed [0:3][2:4] result typedef SHALL live in shared package lane_gate_pkg.
REQ-029 FIFO storage/pointers SHALL be sub-module lane_gate_fifo_mem (params W+chan width, DEPTH); arbiter and gate logic stay in the top.

Verification
REQ-030 Reset, then ch0 valid op XOR a=12'hF0F b=12'h0FF -> in_ready=4'b0001, next cycle out_valid=1, out_data=12'hFF0, out_ch=0, count=1.
REQ-031 All 4 channels valid continuously, out_ready=1 -> grants 0,1,2,3,0... one per cycle; out_ch sequence identical, one cycle later.
REQ-032 out_ready=0, ch2 valid 9 cycles -> 8 accepted, count=8, in_ready=0 on 9th; one pop raises in_ready next cycle; count stays 8 under steady push+pop.
REQ-033 op AND a=12'b0000_xxxx_zzzz b=12'b1x0z_1111_0000 -> out_data=12'b0000_xxxx_0000; op OR same operands -> 12'b1x0x_1111_xxxx... per REQ-019 (OR: 1x0x_111 1_xxxx).
REQ-034 Fill to count=5, assert rst one cycle -> count=0, out_valid=0, rr_ptr=0; ch1 next push appears as sole entry.
REQ-035 Pointer wrap: 20 push/pop pairs with DEPTH=8 -> data order preserved, no loss/duplication (scoreboard).
